// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: FSM states,
// light index width and the direction index type used by the decoder.
package traffic_pkg;

    localparam int LIGHT_W = 2;
    localparam int NUM_DIR = 4;

    typedef logic [LIGHT_W-1:0] dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GREEN = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/traffic_light_sequencer_if.sv
// Request/light bundle between the sequencer and its surroundings.
// The master side supplies enable and car requests and consumes the light.
interface traffic_light_sequencer_if;
    import traffic_pkg::*;

    logic               enable;
    logic [NUM_DIR-1:0] car_waiting;
    dir_t               traffic_light;
    logic               light_valid;
    logic               phase_done;

    modport master (
        output enable,
        output car_waiting,
        input  traffic_light,
        input  light_valid,
        input  phase_done
    );

    modport slave (
        input  enable,
        input  car_waiting,
        output traffic_light,
        output light_valid,
        output phase_done
    );

endinterface

// File: rtl/rr_next_dir.sv
// Rotate-priority picker: first requester after cur (cur+1, cur+2, cur+3,
// then cur itself) wins; with no requests it falls back to cur+1.
module rr_next_dir
    import traffic_pkg::*;
(
    input  dir_t               cur,
    input  logic [NUM_DIR-1:0] req,
    output dir_t               next
);

    dir_t cand;

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        cand = cur;
        next = cur + dir_t'(1);
        for (int k = NUM_DIR; k >= 1; k--) begin
            cand = cur + dir_t'(k);
            if (req[cand]) begin
                next = cand;
            end
        end
    end

endmodule

// File: rtl/traffic_light_sequencer.sv
// Timed GREEN/CLEAR phase controller. Holds the direction index steady for
// a whole GREEN, then an all-stop CLEAR, then picks the next direction
// round-robin over waiting cars. Enable is only honoured at phase edges so
// a stop never truncates a running phase.
module traffic_light_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES = 8,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_light_sequencer_if.slave    bus
);

    if (GREEN_CYCLES < 1 || GREEN_CYCLES > (2 ** CNT_W)) begin : g_bad_green
        $error("GREEN_CYCLES out of range for CNT_W");
    end
    if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > (2 ** CNT_W)) begin : g_bad_clear
        $error("CLEAR_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] GREEN_LOAD = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    dir_t             light_q, light_d;
    logic             valid_q;
    logic             done_q, done_d;
    dir_t             next_dir;

    rr_next_dir u_rr_next_dir (
        .cur  (light_q),
        .req  (bus.car_waiting),
        .next (next_dir)
    );

    // State, phase counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            light_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            light_q <= light_d;
            valid_q <= (state_d == GREEN);
            done_q  <= done_d;
        end
    end

    // Next-state, counter load/decrement and direction selection.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        light_d = light_q;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_d = GREEN;
                    cnt_d   = GREEN_LOAD;
                end
            end
            GREEN: begin
                if (cnt == '0) begin
                    state_d = CLEAR;
                    cnt_d   = CLEAR_LOAD;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == '0) begin
                    if (!bus.enable) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = GREEN;
                        cnt_d   = GREEN_LOAD;
                        light_d = next_dir;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.traffic_light = light_q;
    assign bus.light_valid   = valid_q;
    assign bus.phase_done    = done_q;

endmodule
